// File: rtl/pipe_pkg.sv
// Shared Y86-64 pipeline constants for the decode forwarding / hazard control slice.
package pipe_pkg;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [3:0] RNONE   = 4'hF;

  typedef enum logic [1:0] {
    RET_IDLE,
    RET_R1,
    RET_R2,
    RET_R3
  } retState_e;
endpackage

// File: rtl/pipe_hazard_fwd_ctrl_if.sv
// Decode-side bundle: pipe-stage results in, forwarded operands and pipe controls out.
interface pipe_hazard_fwd_ctrl_if #(
  parameter int DATA_W    = 64,
  parameter int REG_W     = 4,
  parameter int NUM_PORTS = 2,
  parameter int CNT_W     = 32
);
  logic [3:0]                  D_icode;
  logic [DATA_W-1:0]           D_valP;
  logic [NUM_PORTS*REG_W-1:0]  d_src;
  logic [NUM_PORTS*DATA_W-1:0] d_rval;
  logic [3:0]                  E_icode;
  logic [REG_W-1:0]            E_dstM;
  logic                        e_Cnd;
  logic [REG_W-1:0]            e_dstE;
  logic [DATA_W-1:0]           e_valE;
  logic [REG_W-1:0]            M_dstE;
  logic [REG_W-1:0]            M_dstM;
  logic [DATA_W-1:0]           M_valE;
  logic [DATA_W-1:0]           m_valM;
  logic [REG_W-1:0]            W_dstE;
  logic [REG_W-1:0]            W_dstM;
  logic [DATA_W-1:0]           W_valE;
  logic [DATA_W-1:0]           W_valM;
  logic [NUM_PORTS*DATA_W-1:0] d_val;
  logic                        F_stall;
  logic                        D_stall;
  logic                        D_bubble;
  logic                        E_bubble;
  logic [CNT_W-1:0]            stall_cnt;
  logic [CNT_W-1:0]            bubble_cnt;

  modport master (
    output D_icode, D_valP, d_src, d_rval, E_icode, E_dstM, e_Cnd, e_dstE, e_valE,
           M_dstE, M_dstM, M_valE, m_valM, W_dstE, W_dstM, W_valE, W_valM,
    input  d_val, F_stall, D_stall, D_bubble, E_bubble, stall_cnt, bubble_cnt
  );

  modport slave (
    input  D_icode, D_valP, d_src, d_rval, E_icode, E_dstM, e_Cnd, e_dstE, e_valE,
           M_dstE, M_dstM, M_valE, m_valM, W_dstE, W_dstM, W_valE, W_valM,
    output d_val, F_stall, D_stall, D_bubble, E_bubble, stall_cnt, bubble_cnt
  );
endinterface

// File: rtl/fwd_mux_port.sv
// One decode read port: priority forwarding chain from execute, memory and write-back.
module fwd_mux_port
  import pipe_pkg::*;
#(
  parameter int               DATA_W   = 64,
  parameter int               REG_W    = 4,
  parameter bit               IS_PORT0 = 1'b0,
  parameter logic [REG_W-1:0] RNONE    = REG_W'(pipe_pkg::RNONE)
) (
  input  logic [3:0]        dIcode,
  input  logic [DATA_W-1:0] dValP,
  input  logic [REG_W-1:0]  src,
  input  logic [DATA_W-1:0] rval,
  input  logic [REG_W-1:0]  eDstE,
  input  logic [DATA_W-1:0] eValE,
  input  logic [REG_W-1:0]  mDstM,
  input  logic [DATA_W-1:0] mValM,
  input  logic [REG_W-1:0]  mDstE,
  input  logic [DATA_W-1:0] mValE,
  input  logic [REG_W-1:0]  wDstM,
  input  logic [DATA_W-1:0] wValM,
  input  logic [REG_W-1:0]  wDstE,
  input  logic [DATA_W-1:0] wValE,
  output logic [DATA_W-1:0] val
);
  logic usesValP;

  assign usesValP = IS_PORT0 && ((dIcode == IJXX) || (dIcode == ICALL));

  // Youngest producer wins; an RNONE source reads the register file untouched.
  always_comb begin
    val = rval;
    if (usesValP)            val = dValP;
    else if (src == RNONE)   val = rval;
    else if (src == eDstE)   val = eValE;
    else if (src == mDstM)   val = mValM;
    else if (src == mDstE)   val = mValE;
    else if (src == wDstM)   val = wValM;
    else if (src == wDstE)   val = wValE;
  end
endmodule

// File: rtl/pipe_hazard_fwd_ctrl.sv
// Decode forwarding for NUM_PORTS operands plus load-use / mispredict / RET-drain pipe control
// and saturating stall/bubble counters.
module pipe_hazard_fwd_ctrl
  import pipe_pkg::*;
#(
  parameter int               DATA_W    = 64,
  parameter int               REG_W     = 4,
  parameter int               NUM_PORTS = 2,
  parameter logic [REG_W-1:0] RNONE     = REG_W'(pipe_pkg::RNONE),
  parameter int               CNT_W     = 32
) (
  input logic                   clk,
  input logic                   rst,
  pipe_hazard_fwd_ctrl_if.slave bus
);
  localparam int LU_PORTS = (NUM_PORTS < 2) ? NUM_PORTS : 2;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic [NUM_PORTS*DATA_W-1:0] dVal;
  logic                        loadUse;
  logic                        mispred;
  logic                        retPend;
  logic                        fStall, dStall, dBubble, eBubble;
  retState_e                   state, stateNext;
  logic [CNT_W-1:0]            stallCnt, bubbleCnt;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : gPort
    fwd_mux_port #(
      .DATA_W  (DATA_W),
      .REG_W   (REG_W),
      .IS_PORT0(p == 0),
      .RNONE   (RNONE)
    ) uMux (
      .dIcode(bus.D_icode),
      .dValP (bus.D_valP),
      .src   (bus.d_src[p*REG_W +: REG_W]),
      .rval  (bus.d_rval[p*DATA_W +: DATA_W]),
      .eDstE (bus.e_dstE),
      .eValE (bus.e_valE),
      .mDstM (bus.M_dstM),
      .mValM (bus.m_valM),
      .mDstE (bus.M_dstE),
      .mValE (bus.M_valE),
      .wDstM (bus.W_dstM),
      .wValM (bus.W_valM),
      .wDstE (bus.W_dstE),
      .wValE (bus.W_valE),
      .val   (dVal[p*DATA_W +: DATA_W])
    );
  end

  // Only the srcA/srcB ports can consume a pending load.
  always_comb begin
    loadUse = 1'b0;
    if (((bus.E_icode == IMRMOVQ) || (bus.E_icode == IPOPQ)) && (bus.E_dstM != RNONE)) begin
      for (int p = 0; p < LU_PORTS; p++) begin
        if (bus.d_src[p*REG_W +: REG_W] == bus.E_dstM) loadUse = 1'b1;
      end
    end
  end

  assign mispred = (bus.E_icode == IJXX) && !bus.e_Cnd;

  always_comb begin
    stateNext = state;
    retPend   = (state != RET_IDLE) || ((bus.D_icode == IRET) && !mispred);
    fStall    = loadUse || retPend;
    dStall    = loadUse;
    dBubble   = mispred || (retPend && !loadUse);
    eBubble   = mispred || loadUse;
    case (state)
      RET_IDLE: if ((bus.D_icode == IRET) && !loadUse && !mispred) stateNext = RET_R1;
      RET_R1:   stateNext = RET_R2;
      RET_R2:   stateNext = RET_R3;
      RET_R3:   stateNext = RET_IDLE;
      default:  stateNext = RET_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RET_IDLE;
      stallCnt  <= '0;
      bubbleCnt <= '0;
    end else begin
      state <= stateNext;
      if (fStall)             stallCnt  <= satInc(stallCnt);
      if (dBubble || eBubble) bubbleCnt <= satInc(bubbleCnt);
    end
  end

  assign bus.d_val      = dVal;
  assign bus.F_stall    = fStall;
  assign bus.D_stall    = dStall;
  assign bus.D_bubble   = dBubble;
  assign bus.E_bubble   = eBubble;
  assign bus.stall_cnt  = stallCnt;
  assign bus.bubble_cnt = bubbleCnt;
endmodule

// File: tb/tb_pipe_hazard_fwd_ctrl.sv
// Scoreboard bench for pipe_hazard_fwd_ctrl: directed hazard/forwarding cases plus random traffic.
module tb_pipe_hazard_fwd_ctrl;
  localparam int DATA_W    = 64;
  localparam int REG_W     = 4;
  localparam int NUM_PORTS = 2;
  localparam int CNT_W     = 4;
  localparam int CNT_MAX   = 15;

  typedef enum {S_DVAL0, S_DVAL1, S_FST, S_DST, S_DBUB, S_EBUB, S_SCNT, S_BCNT} sel_e;
  typedef struct {
    string       tag;
    sel_e        sel;
    logic [63:0] exp;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  exp_t sbq[$];
  int   mState, mStall, mBub;

  always #5 clk = ~clk;

  pipe_hazard_fwd_ctrl_if #(.DATA_W(DATA_W), .REG_W(REG_W), .NUM_PORTS(NUM_PORTS), .CNT_W(CNT_W)) bus ();

  pipe_hazard_fwd_ctrl #(
    .DATA_W(DATA_W), .REG_W(REG_W), .NUM_PORTS(NUM_PORTS), .RNONE(4'hF), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] obsOf(sel_e s);
    case (s)
      S_DVAL0: return bus.d_val[0 +: DATA_W];
      S_DVAL1: return bus.d_val[DATA_W +: DATA_W];
      S_FST:   return 64'(bus.F_stall);
      S_DST:   return 64'(bus.D_stall);
      S_DBUB:  return 64'(bus.D_bubble);
      S_EBUB:  return 64'(bus.E_bubble);
      S_SCNT:  return 64'(bus.stall_cnt);
      S_BCNT:  return 64'(bus.bubble_cnt);
      default: return '0;
    endcase
  endfunction

  task automatic pushExp(input string tag, input sel_e sel, input logic [63:0] exp);
    exp_t e;
    e.tag = tag; e.sel = sel; e.exp = exp;
    sbq.push_back(e);
  endtask

  // Reference model
  function automatic logic [63:0] mFwd(int p);
    logic [REG_W-1:0]  s = bus.d_src[p*REG_W +: REG_W];
    logic [DATA_W-1:0] r = bus.d_rval[p*DATA_W +: DATA_W];
    if (p == 0 && (bus.D_icode == 4'h7 || bus.D_icode == 4'h8)) return bus.D_valP;
    if (s == 4'hF)        return r;
    if (s == bus.e_dstE)  return bus.e_valE;
    if (s == bus.M_dstM)  return bus.m_valM;
    if (s == bus.M_dstE)  return bus.M_valE;
    if (s == bus.W_dstM)  return bus.W_valM;
    if (s == bus.W_dstE)  return bus.W_valE;
    return r;
  endfunction

  function automatic bit mLoadUse();
    return (bus.E_icode == 4'h5 || bus.E_icode == 4'hB) && bus.E_dstM != 4'hF &&
           (bus.E_dstM == bus.d_src[3:0] || bus.E_dstM == bus.d_src[7:4]);
  endfunction

  function automatic bit mMispred();
    return bus.E_icode == 4'h7 && !bus.e_Cnd;
  endfunction

  function automatic bit mRetPend();
    return mState != 0 || (bus.D_icode == 4'h9 && !mMispred());
  endfunction

  task automatic mReset();
    mState = 0; mStall = 0; mBub = 0;
  endtask

  task automatic pushModel(input string tag);
    bit lu = mLoadUse();
    bit mp = mMispred();
    bit rp = mRetPend();
    pushExp({tag, "/dval0"}, S_DVAL0, mFwd(0));
    pushExp({tag, "/dval1"}, S_DVAL1, mFwd(1));
    pushExp({tag, "/fstall"}, S_FST, 64'(lu | rp));
    pushExp({tag, "/dstall"}, S_DST, 64'(lu));
    pushExp({tag, "/dbubble"}, S_DBUB, 64'(mp | (rp & !lu)));
    pushExp({tag, "/ebubble"}, S_EBUB, 64'(mp | lu));
    pushExp({tag, "/stallcnt"}, S_SCNT, 64'(mStall));
    pushExp({tag, "/bubblecnt"}, S_BCNT, 64'(mBub));
  endtask

  task automatic advanceModel();
    bit lu = mLoadUse();
    bit mp = mMispred();
    bit rp = mRetPend();
    if (!rst) begin
      if ((lu | rp) && mStall < CNT_MAX) mStall++;
      if ((mp | rp | lu) && mBub < CNT_MAX) mBub++;
      case (mState)
        0: if (bus.D_icode == 4'h9 && !lu && !mp) mState = 1;
        1: mState = 2;
        2: mState = 3;
        default: mState = 0;
      endcase
    end
  endtask

  task automatic runCycle(input string tag);
    exp_t e;
    pushModel(tag);
    @(negedge clk);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      checkVal(e.tag, obsOf(e.sel), e.exp);
    end
    checkVal({tag, "/stall_xor_bubble"}, 64'(bus.D_stall & bus.D_bubble), 64'd0);
    advanceModel();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    bus.D_icode = 4'h0;  bus.D_valP = 64'h0000_1000_0000_0008;
    bus.d_src   = 8'hFF; bus.d_rval = {64'hAAAA_0000_0000_0001, 64'hBBBB_0000_0000_0000};
    bus.E_icode = 4'h0;  bus.E_dstM = 4'hF; bus.e_Cnd = 1'b1;
    bus.e_dstE  = 4'hF;  bus.e_valE = 64'h0E;
    bus.M_dstE  = 4'hF;  bus.M_dstM = 4'hF; bus.M_valE = 64'h1E; bus.m_valM = 64'h1D;
    bus.W_dstE  = 4'hF;  bus.W_dstM = 4'hF; bus.W_valE = 64'h2E; bus.W_valM = 64'h2D;
  endtask

  function automatic logic [3:0] pickReg();
    int r = $urandom_range(0, 6);
    return (r == 6) ? 4'hF : 4'(r);
  endfunction

  function automatic logic [3:0] pickIcode();
    logic [3:0] tbl [8] = '{4'h0, 4'h2, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hB};
    return tbl[$urandom_range(0, 7)];
  endfunction

  initial begin
    clearInputs();
    rst = 1'b1;
    mReset();
    @(posedge clk); #1;
    pushExp("reset/stallcnt", S_SCNT, 64'd0);
    pushExp("reset/bubblecnt", S_BCNT, 64'd0);
    pushExp("reset/fstall", S_FST, 64'd0);
    runCycle("reset");
    rst = 1'b0;

    // Forwarding priority
    bus.e_dstE = 4'd3; bus.e_valE = 64'h11; bus.M_dstM = 4'd3; bus.m_valM = 64'h22;
    bus.d_src = {4'hF, 4'd3}; bus.d_rval[63:0] = 64'h99;
    pushExp("fwd_e_over_m", S_DVAL0, 64'h11);
    runCycle("fwd_e_over_m");
    bus.e_dstE = 4'hF; bus.M_dstM = 4'd4; bus.M_dstE = 4'd4; bus.M_valE = 64'h33;
    bus.d_src = {4'd4, 4'd4};
    pushExp("fwd_mM_over_mE", S_DVAL1, 64'h22);
    runCycle("fwd_mM_over_mE");
    bus.M_dstM = 4'hF; bus.M_dstE = 4'hF; bus.W_dstM = 4'd6; bus.W_dstE = 4'd6;
    bus.W_valM = 64'h44; bus.W_valE = 64'h45; bus.d_src = {4'hF, 4'd6};
    pushExp("fwd_wM_over_wE", S_DVAL0, 64'h44);
    runCycle("fwd_wM_over_wE");
    bus.D_icode = 4'h7;
    pushExp("fwd_valp", S_DVAL0, 64'h0000_1000_0000_0008);
    runCycle("fwd_valp");
    clearInputs();
    bus.d_src = {4'hF, 4'hF}; bus.e_dstE = 4'hF; bus.e_valE = 64'h55;
    bus.d_rval[127:64] = 64'h77;
    pushExp("rnone_no_fwd", S_DVAL1, 64'h77);
    runCycle("rnone_no_fwd");

    // Load-use on srcB
    clearInputs();
    bus.E_icode = 4'h5; bus.E_dstM = 4'd2; bus.d_src = {4'd2, 4'hF};
    pushExp("lu/fstall", S_FST, 64'd1);
    pushExp("lu/dstall", S_DST, 64'd1);
    pushExp("lu/ebubble", S_EBUB, 64'd1);
    pushExp("lu/dbubble", S_DBUB, 64'd0);
    runCycle("lu");
    clearInputs();
    pushExp("lu_after/stallcnt", S_SCNT, 64'd1);
    runCycle("lu_after");

    // RET drain: four cycles of stall+bubble, then clear
    bus.D_icode = 4'h9;
    for (int i = 0; i < 4; i++) begin
      pushExp("ret/fstall", S_FST, 64'd1);
      pushExp("ret/dbubble", S_DBUB, 64'd1);
      runCycle("ret");
      bus.D_icode = 4'h0;
    end
    pushExp("ret_done/fstall", S_FST, 64'd0);
    runCycle("ret_done");

    // Reset while in R2 aborts the drain
    bus.D_icode = 4'h9;
    runCycle("ret2_idle");
    bus.D_icode = 4'h0;
    runCycle("ret2_r1");
    rst = 1'b1;
    mReset();
    pushExp("ret2_rst/fstall", S_FST, 64'd0);
    pushExp("ret2_rst/stallcnt", S_SCNT, 64'd0);
    runCycle("ret2_rst");
    rst = 1'b0;
    pushExp("ret2_after/fstall", S_FST, 64'd0);
    runCycle("ret2_after");

    // Mispredict squashes RET
    bus.E_icode = 4'h7; bus.e_Cnd = 1'b0; bus.D_icode = 4'h9;
    pushExp("mp_ret/dbubble", S_DBUB, 64'd1);
    pushExp("mp_ret/ebubble", S_EBUB, 64'd1);
    runCycle("mp_ret");
    clearInputs();
    pushExp("mp_ret_after/fstall", S_FST, 64'd0);
    runCycle("mp_ret_after");

    // Load-use holds RET in IDLE
    bus.E_icode = 4'h5; bus.E_dstM = 4'd2; bus.d_src = {4'hF, 4'd2}; bus.D_icode = 4'h9;
    pushExp("lu_ret/fstall", S_FST, 64'd1);
    pushExp("lu_ret/dbubble", S_DBUB, 64'd0);
    runCycle("lu_ret");
    clearInputs();
    pushExp("lu_ret_after/fstall", S_FST, 64'd0);
    runCycle("lu_ret_after");

    // Counter saturation
    rst = 1'b1;
    mReset();
    runCycle("sat_rst");
    rst = 1'b0;
    bus.E_icode = 4'hB; bus.E_dstM = 4'd1; bus.d_src = {4'hF, 4'd1};
    for (int i = 0; i < 16; i++) runCycle("sat_fill");
    for (int i = 0; i < 2; i++) begin
      pushExp("sat/stallcnt", S_SCNT, 64'hF);
      pushExp("sat/bubblecnt", S_BCNT, 64'hF);
      runCycle("sat_hold");
    end

    // Random traffic against the model
    rst = 1'b1;
    mReset();
    runCycle("rand_rst");
    rst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      bus.D_icode = pickIcode(); bus.E_icode = pickIcode();
      bus.e_Cnd   = 1'($urandom_range(0, 1));
      bus.d_src   = {pickReg(), pickReg()};
      bus.E_dstM  = pickReg(); bus.e_dstE = pickReg();
      bus.M_dstE  = pickReg(); bus.M_dstM = pickReg();
      bus.W_dstE  = pickReg(); bus.W_dstM = pickReg();
      bus.D_valP  = {$urandom, $urandom}; bus.d_rval = {$urandom, $urandom, $urandom, $urandom};
      bus.e_valE  = {$urandom, $urandom}; bus.M_valE = {$urandom, $urandom};
      bus.m_valM  = {$urandom, $urandom}; bus.W_valE = {$urandom, $urandom};
      bus.W_valM  = {$urandom, $urandom};
      runCycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
